weight_bram_reader: RTL and testbench
=====================================

Name: weight_bram_reader

Overview:
Read-side sequencer for one weight BRAM bank (16-bit words, 5-bit address, 28 entries, negedge-registered read port). On START it walks the bank from address 0 to DEPTH-1. It delivers the weights in order to the neuron MAC datapath over a valid/ready stream. It hides the BRAM read latency and absorbs downstream backpressure with a 2-entry output buffer.

Parameters:
DEPTH, 28, number of weights per bank (addresses 0..DEPTH-1)
ADDR_W, 5, BRAM address width; must satisfy 2**ADDR_W >= DEPTH
DATA_W, 16, weight word width

Ports:
CLK  input  1  system clock; all reader logic is on the rising edge
RST  input  1  synchronous, active-high reset
START  input  1  single-cycle request to stream the whole bank
BUSY  output  1  high from the cycle after an accepted START until DONE
DONE  output  1  one-cycle pulse after the last word handshakes
BRAM_ADDR  output  ADDR_W  address to the BRAM
BRAM_EN  output  1  BRAM enable; high only in cycles that issue a read
BRAM_WE  output  1  constant 0; the reader never writes
BRAM_DO  input  DATA_W  BRAM read data
W_DATA  output  DATA_W  weight word to the consumer
W_VALID  output  1  W_DATA is valid
W_READY  input  1  consumer accepts the word when W_VALID and W_READY are both high
W_LAST  output  1  high with the word from address DEPTH-1
W_INDEX  output  ADDR_W  source address of the current W_DATA

Interface decision: one clock (CLK). Reset (RST) is synchronous and active-high.

Behaviour:
- Reset, with RST sampled high at a rising edge:
  - state goes to IDLE.
  - BUSY, DONE, BRAM_EN, W_VALID and W_LAST are 0.
  - BRAM_ADDR, W_DATA and W_INDEX are 0.
  - Buffer count, in-flight flag and issue counter are cleared.
  - A reset mid-stream discards all buffered and in-flight data. No word is presented afterwards.
- Read timing:
  - BRAM_ADDR and BRAM_EN are registered and change at a rising edge k.
  - The BRAM captures BRAM_DO at the following falling edge.
  - The reader samples BRAM_DO at rising edge k+1.
  - Read latency is therefore exactly 1 cycle. Each read sets an in-flight flag for that one cycle.
- Buffer:
  - 2-entry FIFO of {data, index, last}.
  - The head drives W_DATA, W_INDEX and W_LAST.
  - W_VALID = (count != 0).
- Issue rule: issue a read in a cycle when all of the following hold:
  - state is RUN
  - the issue counter is less than DEPTH
  - (count + inflight - pop) < 2, where pop = W_VALID & W_READY in the same cycle.
  - This guarantees the FIFO never overflows and sustains 1 word/cycle while W_READY stays high.
- States:
  - IDLE: START=1 clears the issue counter and moves to RUN. BUSY rises in the next cycle.
  - RUN: issues reads per the issue rule. BRAM_ADDR = issue counter. When the read for address DEPTH-1 is issued, move to DRAIN.
  - DRAIN: no reads are issued. When the handshake of the W_LAST word completes, pulse DONE for 1 cycle, drop BUSY in the same cycle DONE rises, and return to IDLE.
- START while BUSY is ignored. START and RST high together: RST wins.
- Stall rule: while W_VALID=1 and W_READY=0, W_DATA, W_INDEX and W_LAST hold stable. W_VALID never drops without a handshake.
- BRAM_EN is 0 in IDLE, in DRAIN, and in any RUN cycle where the issue rule fails. BRAM_ADDR holds its last value when BRAM_EN is 0.
- Simultaneous events: a push from the BRAM and a pop in the same cycle leave count unchanged. The word order is preserved.
- Wrap-around: the issue counter stops at DEPTH and never wraps. Addresses DEPTH..2**ADDR_W-1 are never driven with BRAM_EN=1.
- Output order is strictly ascending: W_INDEX takes 0,1,...,DEPTH-1 exactly once each.

Test Plan:
- Bank preloaded with word i = 16'h0100+i, W_READY held at 1, START pulsed at cycle 0 -> BRAM_EN high in cycles 1..28 with addresses 0..27. W_VALID high in cycles 2..29 with data 16'h0100..16'h011B. W_LAST high only in cycle 29. DONE pulses in cycle 30. BUSY high in cycles 1..29.
- W_READY held at 0 after START -> exactly 2 reads are issued (addresses 0 and 1), then BRAM_EN stays 0. W_DATA holds at 16'h0100 throughout. Releasing W_READY resumes the stream in order with no lost or duplicated words.
- Random W_READY (50% duty) -> 28 handshakes with W_INDEX 0..27 in order. Data matches the BRAM contents. The FIFO count never exceeds 2. Exactly one DONE pulse.
- START re-pulsed at cycles 5 and 10 mid-stream -> no effect. The single stream completes as in the first scenario.
- RST asserted in cycle 12 of a stream -> in the next cycle all outputs are at their reset values. A new START streams from address 0, and the first W_DATA is 16'h0100.
- Over all scenarios -> BRAM_WE is never 1, and BRAM_EN is never 1 with BRAM_ADDR > 27.

Source files
------------

// File: rtl/weight_bram_reader_if.sv
// rtl/weight_bram_reader_if.sv - BRAM read port and weight stream bundle for weight_bram_reader
//
// Signals:
//   BRAM_ADDR, BRAM_EN, BRAM_WE : reader -> BRAM read request (WE always 0)
//   BRAM_DO                     : BRAM -> reader read data (registered in the BRAM on the falling edge)
//   W_DATA, W_INDEX, W_LAST     : reader -> consumer weight word, its source address, final-word marker
//   W_VALID / W_READY           : stream handshake, a word moves when both are high at a rising edge
// Modports: master = reader side, slave = BRAM plus consumer side.
interface weight_bram_reader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] BRAM_ADDR;
  logic              BRAM_EN;
  logic              BRAM_WE;
  logic [DATA_W-1:0] BRAM_DO;
  logic [DATA_W-1:0] W_DATA;
  logic              W_VALID;
  logic              W_READY;
  logic              W_LAST;
  logic [ADDR_W-1:0] W_INDEX;

  modport master (
    output BRAM_ADDR, BRAM_EN, BRAM_WE,
    input  BRAM_DO,
    output W_DATA, W_VALID, W_LAST, W_INDEX,
    input  W_READY
  );

  modport slave (
    input  BRAM_ADDR, BRAM_EN, BRAM_WE,
    output BRAM_DO,
    input  W_DATA, W_VALID, W_LAST, W_INDEX,
    output W_READY
  );
endinterface

// File: rtl/weight_bram_reader.sv
// rtl/weight_bram_reader.sv - streams one weight BRAM bank (addresses 0..DEPTH-1) to the MAC datapath
//
// Ports:
//   CLK   : clock, all logic on the rising edge
//   RST   : synchronous active-high reset
//   START : single-cycle request to stream the whole bank (ignored while BUSY)
//   BUSY  : high from the cycle after an accepted START until DONE
//   DONE  : one-cycle pulse after the last word handshakes
//   bus   : weight_bram_reader_if.master (BRAM read port + weight stream)
module weight_bram_reader #(
  parameter int DEPTH  = 28,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        START,
  output logic                        BUSY,
  output logic                        DONE,
  weight_bram_reader_if.master        bus
);
  // Issue counter must be able to hold DEPTH itself (the "all issued" value).
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  issue_cnt, issue_cnt_next;
  logic              issue;
  logic [ADDR_W-1:0] issue_addr;
  logic              done_next;

  logic              bram_en_q;
  logic [ADDR_W-1:0] bram_addr_q;

  logic [DATA_W-1:0] buf_data [2];
  logic [ADDR_W-1:0] buf_idx  [2];
  logic              buf_last [2];
  logic              rd_ptr, wr_ptr;
  logic [1:0]        count;

  logic              push, pop;
  logic [2:0]        occ;

  // A read presented last cycle (bram_en_q) is the in-flight word; it lands now.
  assign push = bram_en_q;
  assign pop  = (count != 2'd0) && bus.W_READY;
  // Occupancy the FIFO will have after this edge; a new read may only be
  // presented if that leaves a free slot for its data one cycle later.
  assign occ  = 3'(count) + 3'(bram_en_q) - 3'(pop);

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next     = state;
    issue          = 1'b0;
    issue_addr     = issue_cnt[ADDR_W-1:0];
    issue_cnt_next = issue_cnt;
    done_next      = 1'b0;
    case (state)
      IDLE: begin
        // The first read goes out together with the move to RUN so that
        // BRAM_EN is already high in the first BUSY cycle.
        if (START) begin
          state_next     = RUN;
          issue          = 1'b1;
          issue_addr     = '0;
          issue_cnt_next = CNT_W'(1);
        end
      end
      RUN: begin
        if (issue_cnt < CNT_W'(DEPTH) && occ < 3'd2) begin
          issue          = 1'b1;
          issue_cnt_next = issue_cnt + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (pop && bus.W_LAST) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (issue && issue_cnt_next == CNT_W'(DEPTH)) state_next = DRAIN;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      issue_cnt   <= '0;
      bram_en_q   <= 1'b0;
      bram_addr_q <= '0;
      DONE        <= 1'b0;
      count       <= 2'd0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
        buf_idx[i]  <= '0;
        buf_last[i] <= 1'b0;
      end
    end else begin
      issue_cnt <= issue_cnt_next;
      bram_en_q <= issue;
      DONE      <= done_next;
      if (issue) bram_addr_q <= issue_addr;
      if (push) begin
        buf_data[wr_ptr] <= bus.BRAM_DO;
        buf_idx[wr_ptr]  <= bram_addr_q;
        buf_last[wr_ptr] <= (bram_addr_q == ADDR_W'(DEPTH - 1));
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign BUSY          = (state != IDLE);
  assign bus.BRAM_ADDR = bram_addr_q;
  assign bus.BRAM_EN   = bram_en_q;
  assign bus.BRAM_WE   = 1'b0;
  assign bus.W_VALID   = (count != 2'd0);
  assign bus.W_DATA    = buf_data[rd_ptr];
  assign bus.W_INDEX   = buf_idx[rd_ptr];
  assign bus.W_LAST    = bus.W_VALID & buf_last[rd_ptr];
endmodule

// File: tb/tb_weight_bram_reader.sv
// tb/tb_weight_bram_reader.sv - self-checking bench for weight_bram_reader
module tb_weight_bram_reader;
  localparam int DEPTH = 28;

  logic clk, rst, start;
  logic busy, done;
  logic [15:0] mem [0:31];

  int tests, fails;
  int cyc, en_cnt, hs_cnt, done_cnt, last_hs_cyc;
  bit stall_prev;
  logic [15:0] prev_data;
  logic [4:0]  prev_idx;
  logic        prev_last;

  weight_bram_reader_if #(.ADDR_W(5), .DATA_W(16)) bus ();

  weight_bram_reader #(.DEPTH(DEPTH), .ADDR_W(5), .DATA_W(16)) dut (
    .CLK   (clk),
    .RST   (rst),
    .START (start),
    .BUSY  (busy),
    .DONE  (done),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model: read port registered on the falling edge.
  always @(negedge clk) if (bus.BRAM_EN === 1'b1) bus.BRAM_DO <= mem[bus.BRAM_ADDR];

  task automatic fill_ramp();
    for (int i = 0; i < 32; i++) mem[i] = 16'(16'h0100 + i);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
  endtask

  task automatic begin_stream();
    cyc = -1; en_cnt = 0; hs_cnt = 0; done_cnt = 0; last_hs_cyc = -10;
    stall_prev = 1'b0;
  endtask

  // One cycle: drive START/W_READY at the falling edge, then score the
  // cycle against the stream model (n-th read is address n, n-th handshake
  // is word n, FIFO holds reads-presented-before minus handshakes-before).
  task automatic watch_cycle(input bit rdy, input bit st);
    int occ;
    @(negedge clk);
    start = st;
    bus.W_READY = rdy;
    cyc++;
    occ = en_cnt - hs_cnt;
    tests++;
    if (bus.BRAM_WE !== 1'b0) begin
      fails++; $display("FAIL bram_we cyc=%0d got=%b want=0", cyc, bus.BRAM_WE);
    end
    tests++;
    if (bus.BRAM_EN === 1'b1 && bus.BRAM_ADDR > 5'd27) begin
      fails++; $display("FAIL addr_range cyc=%0d got=%0d want<=27", cyc, bus.BRAM_ADDR);
    end
    tests++;
    if (occ > 2 || occ < 0) begin
      fails++; $display("FAIL fifo_occupancy cyc=%0d got=%0d want 0..2", cyc, occ);
    end
    tests++;
    if (bus.W_VALID !== (occ > 0)) begin
      fails++; $display("FAIL valid_vs_model cyc=%0d got=%b want=%b", cyc, bus.W_VALID, occ > 0);
    end
    if (stall_prev) begin
      tests++;
      if (bus.W_VALID !== 1'b1 || bus.W_DATA !== prev_data || bus.W_INDEX !== prev_idx || bus.W_LAST !== prev_last) begin
        fails++;
        $display("FAIL stall_hold cyc=%0d got v=%b d=%h i=%0d l=%b want v=1 d=%h i=%0d l=%b",
                 cyc, bus.W_VALID, bus.W_DATA, bus.W_INDEX, bus.W_LAST, prev_data, prev_idx, prev_last);
      end
    end
    if (bus.BRAM_EN === 1'b1) begin
      tests++;
      if (bus.BRAM_ADDR !== 5'(en_cnt)) begin
        fails++; $display("FAIL read_order cyc=%0d got=%0d want=%0d", cyc, bus.BRAM_ADDR, en_cnt);
      end
      en_cnt++;
    end
    if (done === 1'b1) begin
      tests++;
      if (hs_cnt != DEPTH || last_hs_cyc != cyc - 1) begin
        fails++; $display("FAIL done_timing cyc=%0d got hs=%0d last_hs=%0d want hs=%0d last_hs=%0d",
                          cyc, hs_cnt, last_hs_cyc, DEPTH, cyc - 1);
      end
      done_cnt++;
    end
    if (bus.W_VALID === 1'b1 && rdy) begin
      tests++;
      if (hs_cnt >= DEPTH) begin
        fails++; $display("FAIL extra_word cyc=%0d got idx=%0d want none", cyc, bus.W_INDEX);
      end else if (bus.W_INDEX !== 5'(hs_cnt) || bus.W_DATA !== mem[hs_cnt] ||
                   bus.W_LAST !== (hs_cnt == DEPTH - 1)) begin
        fails++;
        $display("FAIL handshake_word cyc=%0d got i=%0d d=%h l=%b want i=%0d d=%h l=%b",
                 cyc, bus.W_INDEX, bus.W_DATA, bus.W_LAST, hs_cnt, mem[hs_cnt], hs_cnt == DEPTH - 1);
      end
      hs_cnt++;
      last_hs_cyc = cyc;
    end
    stall_prev = (bus.W_VALID === 1'b1) && !rdy;
    prev_data  = bus.W_DATA;
    prev_idx   = bus.W_INDEX;
    prev_last  = bus.W_LAST;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; bus.W_READY = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({busy, done, bus.BRAM_EN, bus.W_VALID, bus.W_LAST} !== 5'b0 ||
        bus.BRAM_ADDR !== 5'd0 || bus.W_DATA !== 16'd0 || bus.W_INDEX !== 5'd0) begin
      fails++;
      $display("FAIL reset_values got b=%b d=%b en=%b v=%b l=%b a=%0d wd=%h wi=%0d want all 0",
               busy, done, bus.BRAM_EN, bus.W_VALID, bus.W_LAST, bus.BRAM_ADDR, bus.W_DATA, bus.W_INDEX);
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || bus.BRAM_EN !== 1'b0) begin
      fails++; $display("FAIL rst_beats_start got busy=%b en=%b want 0 0", busy, bus.BRAM_EN);
    end
  endtask

  task automatic test_full_rate();
    logic [4:0] got, exp;
    fill_ramp();
    begin_stream();
    for (int c = 0; c <= 34; c++) begin
      watch_cycle(1'b1, c == 0);
      got = {busy, bus.BRAM_EN, bus.W_VALID, bus.W_LAST, done};
      exp = {c >= 1 && c <= 29, c >= 1 && c <= 28, c >= 2 && c <= 29, c == 29, c == 30};
      tests++;
      if (got !== exp) begin
        fails++; $display("FAIL full_rate_timing cyc=%0d got busy/en/v/l/done=%b want=%b", c, got, exp);
      end
      if (c >= 2 && c <= 29) begin
        tests++;
        if (bus.W_DATA !== 16'(256 + c - 2)) begin
          fails++; $display("FAIL full_rate_data cyc=%0d got=%h want=%h", c, bus.W_DATA, 16'(256 + c - 2));
        end
      end
    end
    tests++;
    if (hs_cnt != DEPTH || done_cnt != 1) begin
      fails++; $display("FAIL full_rate_totals got hs=%0d done=%0d want %0d 1", hs_cnt, done_cnt, DEPTH);
    end
  endtask

  task automatic test_backpressure();
    fill_ramp();
    begin_stream();
    watch_cycle(1'b0, 1'b1);
    for (int c = 1; c <= 20; c++) begin
      watch_cycle(1'b0, 1'b0);
      if (c >= 2) begin
        tests++;
        if (bus.W_VALID !== 1'b1 || bus.W_DATA !== 16'h0100) begin
          fails++; $display("FAIL stall_head cyc=%0d got v=%b d=%h want v=1 d=0100", c, bus.W_VALID, bus.W_DATA);
        end
      end
    end
    tests++;
    if (en_cnt != 2) begin
      fails++; $display("FAIL stall_reads got=%0d want=2", en_cnt);
    end
    for (int c = 0; c < 100 && done_cnt == 0; c++) watch_cycle(1'b1, 1'b0);
    repeat (3) watch_cycle(1'b1, 1'b0);
    tests++;
    if (hs_cnt != DEPTH || done_cnt != 1) begin
      fails++; $display("FAIL resume_totals got hs=%0d done=%0d want %0d 1", hs_cnt, done_cnt, DEPTH);
    end
  endtask

  task automatic test_random_ready();
    for (int r = 0; r < 3; r++) begin
      fill_random();
      begin_stream();
      watch_cycle(1'($urandom_range(0, 1)), 1'b1);
      for (int c = 0; c < 400 && done_cnt == 0; c++) watch_cycle(1'($urandom_range(0, 1)), 1'b0);
      repeat (4) watch_cycle(1'($urandom_range(0, 1)), 1'b0);
      tests++;
      if (hs_cnt != DEPTH || done_cnt != 1 || busy !== 1'b0) begin
        fails++; $display("FAIL random_totals run=%0d got hs=%0d done=%0d busy=%b want %0d 1 0",
                          r, hs_cnt, done_cnt, busy, DEPTH);
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [2:0] got, exp;
    fill_ramp();
    begin_stream();
    for (int c = 0; c <= 36; c++) begin
      watch_cycle(1'b1, c == 0 || c == 5 || c == 10);
      got = {busy, bus.BRAM_EN, done};
      exp = {c >= 1 && c <= 29, c >= 1 && c <= 28, c == 30};
      tests++;
      if (got !== exp) begin
        fails++; $display("FAIL restart_ignored cyc=%0d got busy/en/done=%b want=%b", c, got, exp);
      end
    end
    tests++;
    if (hs_cnt != DEPTH || en_cnt != DEPTH || done_cnt != 1) begin
      fails++; $display("FAIL restart_totals got hs=%0d rd=%0d done=%0d want %0d %0d 1",
                        hs_cnt, en_cnt, done_cnt, DEPTH, DEPTH);
    end
  endtask

  task automatic test_mid_reset();
    fill_ramp();
    begin_stream();
    for (int c = 0; c <= 12; c++) watch_cycle(1'b1, c == 0);
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({busy, done, bus.BRAM_EN, bus.W_VALID, bus.W_LAST} !== 5'b0 ||
        bus.BRAM_ADDR !== 5'd0 || bus.W_DATA !== 16'd0 || bus.W_INDEX !== 5'd0) begin
      fails++;
      $display("FAIL mid_reset_values got b=%b d=%b en=%b v=%b l=%b a=%0d wd=%h wi=%0d want all 0",
               busy, done, bus.BRAM_EN, bus.W_VALID, bus.W_LAST, bus.BRAM_ADDR, bus.W_DATA, bus.W_INDEX);
    end
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      tests++;
      if (bus.W_VALID !== 1'b0 || bus.BRAM_EN !== 1'b0 || busy !== 1'b0) begin
        fails++; $display("FAIL post_reset_quiet got v=%b en=%b busy=%b want 0 0 0", bus.W_VALID, bus.BRAM_EN, busy);
      end
    end
    begin_stream();
    for (int c = 0; c < 100 && done_cnt == 0; c++) begin
      watch_cycle(1'b1, c == 0);
      if (c == 2) begin
        tests++;
        if (bus.W_VALID !== 1'b1 || bus.W_DATA !== 16'h0100 || bus.W_INDEX !== 5'd0) begin
          fails++; $display("FAIL restart_first_word got v=%b d=%h i=%0d want 1 0100 0", bus.W_VALID, bus.W_DATA, bus.W_INDEX);
        end
      end
    end
    tests++;
    if (hs_cnt != DEPTH || done_cnt != 1) begin
      fails++; $display("FAIL restart_totals got hs=%0d done=%0d want %0d 1", hs_cnt, done_cnt, DEPTH);
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1; start = 1'b0; bus.W_READY = 1'b0;
    fill_ramp();
    test_reset();
    test_full_rate();
    test_backpressure();
    test_random_ready();
    test_start_ignored();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
